// File: rtl/uart_cmd_decoder.sv
// Host command decoder: turns framed UART bytes into register reads/writes and one response byte.
// Optional trailing XOR checksum per frame when UART_CMD_CHECKSUM_EN is defined.
module uart_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 1200000,
    parameter int ADDR_BITS      = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [7:0]           rx_data_i,
    input  logic                 rx_valid_i,
    output logic [7:0]           tx_data_o,
    output logic                 tx_write_o,
    input  logic                 tx_ready_i,
    output logic [ADDR_BITS-1:0] reg_addr_o,
    output logic [7:0]           reg_wdata_o,
    output logic                 reg_write_o,
    output logic                 reg_read_o,
    input  logic [7:0]           reg_rdata_i,
    output logic                 error_o,
    output logic                 busy_o
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_PING  = 8'h50;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_BAD  = 8'h3F;
`ifdef UART_CMD_CHECKSUM_EN
    localparam logic [7:0] RSP_SUM  = 8'h21;
`endif

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        DO_WRITE,
        DO_READ,
        READ_WAIT,
        RESP
`ifdef UART_CMD_CHECKSUM_EN
        , GET_SUM
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             opcode_q, opcode_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic [7:0]             resp_q, resp_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   error_q, error_d;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]             sum_q, sum_d;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            resp_q   <= '0;
            tmo_q    <= '0;
            error_q  <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            resp_q   <= resp_d;
            tmo_q    <= tmo_d;
            error_q  <= error_d;
`ifdef UART_CMD_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    // tmo_d defaults to zero so the counter clears on every accepted byte and state entry
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        resp_d   = resp_q;
        tmo_d    = '0;
        error_d  = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (rx_valid_i) begin
                    opcode_d = rx_data_i;
`ifdef UART_CMD_CHECKSUM_EN
                    sum_d    = rx_data_i;
`endif
                    if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
                        state_d = GET_ADDR;
                    end else if (rx_data_i == OP_PING) begin
`ifdef UART_CMD_CHECKSUM_EN
                        state_d = GET_SUM;
`else
                        resp_d  = OP_PING;
                        state_d = RESP;
`endif
                    end else begin
                        resp_d  = RSP_BAD;
                        error_d = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_valid_i) begin
                    addr_d = rx_data_i[ADDR_BITS-1:0];
`ifdef UART_CMD_CHECKSUM_EN
                    sum_d  = sum_q ^ rx_data_i;
`endif
                    if (opcode_q == OP_WRITE) begin
                        state_d = GET_DATA;
                    end else begin
`ifdef UART_CMD_CHECKSUM_EN
                        state_d = GET_SUM;
`else
                        state_d = DO_READ;
`endif
                    end
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            GET_DATA: begin
                if (rx_valid_i) begin
                    wdata_d = rx_data_i;
`ifdef UART_CMD_CHECKSUM_EN
                    sum_d   = sum_q ^ rx_data_i;
                    state_d = GET_SUM;
`else
                    state_d = DO_WRITE;
`endif
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            GET_SUM: begin
                if (rx_valid_i) begin
                    if (rx_data_i == sum_q) begin
                        if (opcode_q == OP_WRITE) begin
                            state_d = DO_WRITE;
                        end else if (opcode_q == OP_READ) begin
                            state_d = DO_READ;
                        end else begin
                            resp_d  = OP_PING;
                            state_d = RESP;
                        end
                    end else begin
                        resp_d  = RSP_SUM;
                        error_d = 1'b1;
                        state_d = RESP;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
`endif
            DO_WRITE: begin
                error_d = rx_valid_i;
                resp_d  = RSP_OK;
                state_d = RESP;
            end
            DO_READ: begin
                error_d = rx_valid_i;
                state_d = READ_WAIT;
            end
            READ_WAIT: begin
                error_d = rx_valid_i;
                resp_d  = reg_rdata_i;
                state_d = RESP;
            end
            RESP: begin
                error_d = rx_valid_i;
                if (tx_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_data_o   = (state_q == RESP) ? resp_q : 8'h00;
    assign tx_write_o  = (state_q == RESP) && tx_ready_i;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_write_o = (state_q == DO_WRITE);
    assign reg_read_o  = (state_q == DO_READ);
    assign error_o     = error_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed scenarios plus random frames against a frame-level model.
module tb_uart_cmd_decoder;

    localparam int TMO = 100;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] reg_rdata = 8'h00;

    logic [7:0] tx_data_o;
    logic       tx_write_o;
    logic [7:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_write_o;
    logic       reg_read_o;
    logic       error_o;
    logic       busy_o;

    uart_cmd_decoder #(.TIMEOUT_CYCLES(TMO), .ADDR_BITS(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx_data_i   (rx_data),
        .rx_valid_i  (rx_valid),
        .tx_data_o   (tx_data_o),
        .tx_write_o  (tx_write_o),
        .tx_ready_i  (tx_ready),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_write_o (reg_write_o),
        .reg_read_o  (reg_read_o),
        .reg_rdata_i (reg_rdata),
        .error_o     (error_o),
        .busy_o      (busy_o)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    int cyc = 0, wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, err_cnt = 0;
    int last_rx_cyc = 0, last_wr_cyc = 0;
    logic [7:0] last_tx = 8'h00, last_wa = 8'h00, last_wd = 8'h00, last_ra = 8'h00;
    logic [7:0] regs  [256];
    logic [7:0] model [256];

    // Event monitor sampled mid-cycle; the register file the DUT talks to lives here too.
    always @(negedge clock) begin
        cyc++;
        if (rx_valid) last_rx_cyc = cyc;
        if (reg_write_o) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            last_wa = reg_addr_o;
            last_wd = reg_wdata_o;
            regs[reg_addr_o] = reg_wdata_o;
        end
        if (reg_read_o) begin
            rd_cnt++;
            last_ra = reg_addr_o;
        end
        if (tx_write_o) begin
            tx_cnt++;
            last_tx = tx_data_o;
        end
        if (error_o) err_cnt++;
    end

    always @(posedge clock) begin
        reg_rdata <= reg_read_o ? regs[reg_addr_o] : 8'hEE;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 400) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
        repeat (3) @(negedge clock);
    endtask

    task automatic run_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                             input int ready_delay);
        int s_wr, s_rd, s_tx, s_err;
        logic [7:0] exp_tx;
        int exp_wr, exp_rd, exp_err;
        s_wr = wr_cnt; s_rd = rd_cnt; s_tx = tx_cnt; s_err = err_cnt;
        exp_wr = 0; exp_rd = 0; exp_err = 0;
        if (op == 8'h57) begin
            exp_tx = 8'h4B; exp_wr = 1; model[a] = d;
        end else if (op == 8'h52) begin
            exp_tx = model[a]; exp_rd = 1;
        end else if (op == 8'h50) begin
            exp_tx = 8'h50;
        end else begin
            exp_tx = 8'h3F; exp_err = 1;
        end
        tx_ready = (ready_delay == 0);
        send_byte(op);
        if (op == 8'h57 || op == 8'h52) send_byte(a);
        if (op == 8'h57) send_byte(d);
        if (ready_delay > 0) begin
            repeat (ready_delay) @(posedge clock);
            #1;
            tx_ready = 1'b1;
        end
        wait_idle("frame");
        check("frame_tx_count", tx_cnt - s_tx, 1);
        check("frame_tx_data", {24'd0, last_tx}, {24'd0, exp_tx});
        check("frame_wr_count", wr_cnt - s_wr, exp_wr);
        check("frame_rd_count", rd_cnt - s_rd, exp_rd);
        check("frame_err_count", err_cnt - s_err, exp_err);
        if (op == 8'h57) begin
            check("frame_wr_addr", {24'd0, last_wa}, {24'd0, a});
            check("frame_wr_data", {24'd0, last_wd}, {24'd0, d});
            check("frame_wr_latency", last_wr_cyc - last_rx_cyc, 1);
        end
        if (op == 8'h52) check("frame_rd_addr", {24'd0, last_ra}, {24'd0, a});
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_wr, s_rd, s_tx, s_err, n;
        logic [7:0] op, a, d;
        for (int i = 0; i < 256; i++) begin
            regs[i]  = 8'h00;
            model[i] = 8'h00;
        end

        // outputs held at zero in reset even with a bad byte on the input
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        repeat (3) @(negedge clock);
        check("reset_outputs", {tx_data_o, tx_write_o, reg_addr_o, reg_wdata_o, reg_write_o,
                                reg_read_o, error_o, busy_o}, 32'd0);
        rx_valid = 1'b0;
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("post_reset_err", err_cnt, 0);

        // write / read paths
        run_frame(8'h57, 8'h12, 8'hA5, 0);
        run_frame(8'h57, 8'h34, 8'h5C, 0);
        run_frame(8'h52, 8'h34, 8'h00, 0);
        run_frame(8'h52, 8'h12, 8'h00, 2);

        // backpressure with an overrun byte while the response is pending
        s_wr = wr_cnt; s_rd = rd_cnt; s_tx = tx_cnt; s_err = err_cnt;
        tx_ready = 1'b0;
        send_byte(8'h50);
        send_byte(8'h57);
        repeat (50) @(negedge clock);
        check("bp_no_tx", tx_cnt - s_tx, 0);
        check("bp_overrun_err", err_cnt - s_err, 1);
        check("bp_busy", {31'd0, busy_o}, 32'd1);
        @(posedge clock);
        #1 tx_ready = 1'b1;
        wait_idle("bp");
        check("bp_tx_count", tx_cnt - s_tx, 1);
        check("bp_tx_data", {24'd0, last_tx}, 32'h50);
        check("bp_no_access", (wr_cnt - s_wr) + (rd_cnt - s_rd), 0);
        check("bp_err_total", err_cnt - s_err, 1);

        // inter-byte timeout
        s_wr = wr_cnt; s_tx = tx_cnt; s_err = err_cnt;
        send_byte(8'h57);
        send_byte(8'h01);
        n = 0;
        while (busy_o && n < 150) begin
            @(negedge clock);
            n++;
        end
        check("tmo_cycles", n, 101);
        repeat (3) @(negedge clock);
        check("tmo_err", err_cnt - s_err, 1);
        check("tmo_no_write", wr_cnt - s_wr, 0);
        check("tmo_no_tx", tx_cnt - s_tx, 0);
        run_frame(8'h50, 8'h00, 8'h00, 0);

        // bad opcode
        run_frame(8'h41, 8'h00, 8'h00, 0);

        // back-to-back pings: second opcode lands in the first idle cycle
        s_tx = tx_cnt; s_err = err_cnt;
        send_byte(8'h50);
        send_byte(8'h50);
        wait_idle("b2b");
        check("b2b_tx_count", tx_cnt - s_tx, 2);
        check("b2b_no_err", err_cnt - s_err, 0);

        // asynchronous reset mid-frame
        s_wr = wr_cnt; s_tx = tx_cnt;
        send_byte(8'h57);
        check("rst_busy_before", {31'd0, busy_o}, 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check("rst_async_outputs", {tx_data_o, tx_write_o, reg_write_o, reg_read_o, error_o,
                                    busy_o}, 32'd0);
        @(negedge clock);
        #2 reset_n = 1'b1;
        repeat (20) @(negedge clock);
        check("rst_no_tx", tx_cnt - s_tx, 0);
        check("rst_no_write", wr_cnt - s_wr, 0);
        check("rst_idle", {31'd0, busy_o}, 32'd0);

        // random frames; reset cleared the address register but not the bench register file
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: op = 8'h57;
                1: op = 8'h52;
                2: op = 8'h50;
                default: begin
                    op = 8'($urandom_range(0, 255));
                    while (op == 8'h57 || op == 8'h52 || op == 8'h50) op = 8'($urandom_range(0, 255));
                end
            endcase
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            run_frame(op, a, d, $urandom_range(0, 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Byte-level command decoder downstream of the UART receiver (consumes its data/valid byte stream).
- Turns framed host commands into single-cycle register-bus reads and writes.
- Emits one response byte per command into the transmit FIFO's write port, which feeds the UART transmitter.
- Gives the host a simple register-poke channel over the 115200-baud link.

Parameters:
- TIMEOUT_CYCLES, 1200000, idle cycles allowed between bytes of one frame before abort (100 ms at 12 MHz).
- ADDR_BITS, 8, register address width; the address byte is truncated to this width (must be ≤ 8).

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- rx_data_i  input  8  received byte
- rx_valid_i  input  1  one-cycle strobe, rx_data_i valid
- tx_data_o  output  8  response byte to TX FIFO
- tx_write_o  output  1  one-cycle write strobe to TX FIFO
- tx_ready_i  input  1  TX FIFO has space
- reg_addr_o  output  ADDR_BITS  register address
- reg_wdata_o  output  8  register write data
- reg_write_o  output  1  one-cycle register write strobe
- reg_read_o  output  1  one-cycle register read strobe
- reg_rdata_i  input  8  read data, valid exactly 1 cycle after reg_read_o
- error_o  output  1  one-cycle pulse on timeout, overrun or bad opcode
- busy_o  output  1  high whenever state != IDLE

Behaviour:
- Reset: one clock domain; reset_n is asynchronous and active-low. While reset_n is low:
  - All outputs are 0.
  - State is IDLE and the timeout counter is 0.
  - Reset mid-frame discards the partial frame; no response is sent.
- Frame formats (bytes):
  - 'W'(0x57) addr data → register write, respond 'K'(0x4B).
  - 'R'(0x52) addr → register read, respond with the read data.
  - 'P'(0x50) → respond 'P'.
  - Any other opcode → respond '?'(0x3F) and pulse error_o.
- States: IDLE, GET_ADDR, GET_DATA, DO_WRITE, DO_READ, READ_WAIT, RESP.
- IDLE:
  - On rx_valid_i, latch the opcode.
  - 'W'/'R' → GET_ADDR.
  - 'P' → RESP with resp='P'.
  - Other opcodes → RESP with resp='?' and error_o pulsed in the same cycle the state changes.
- GET_ADDR: on rx_valid_i latch reg_addr_o; 'W' → GET_DATA, 'R' → DO_READ.
- GET_DATA: on rx_valid_i latch reg_wdata_o → DO_WRITE.
- DO_WRITE: reg_write_o=1 for exactly this cycle; resp='K' → RESP.
  - Write strobe occurs 1 cycle after the data-byte strobe.
- DO_READ: reg_read_o=1 for exactly this cycle → READ_WAIT.
- READ_WAIT: capture reg_rdata_i into resp → RESP.
- RESP:
  - tx_data_o=resp at all times in RESP.
  - tx_write_o=1 in the first cycle with tx_ready_i=1, then → IDLE.
  - If tx_ready_i stays low, RESP waits indefinitely; no timeout applies in RESP.
- reg_addr_o and reg_wdata_o hold their last latched values outside strobes.
- Overrun: rx_valid_i in DO_WRITE, DO_READ, READ_WAIT or RESP:
  - The byte is dropped and error_o pulses.
  - State and response are unaffected; the byte is not reinterpreted as an opcode.
- Timeout:
  - The counter runs in GET_ADDR/GET_DATA (and GET_SUM when the optional feature is compiled in).
  - It clears on every accepted byte and on state entry.
  - When it reaches TIMEOUT_CYCLES-1: → IDLE, error_o pulses, no response, no register access.
- Simultaneous events: a byte arriving in the same cycle the timeout expires is accepted and the timeout is ignored.
- Counter width is $clog2(TIMEOUT_CYCLES); the counter saturates and never wraps.
- Back-to-back frames: a new opcode is accepted in the IDLE cycle immediately after the RESP write.

Optional Feature:
- Macro: UART_CMD_CHECKSUM_EN.
- When defined:
  - Every frame gains a trailing checksum byte equal to the XOR of all preceding frame bytes, collected in a new GET_SUM state.
  - Register access and normal response happen only on a checksum match.
  - On mismatch: no register access, resp='!'(0x21), error_o pulses.
  - A bad opcode still responds '?' immediately, with no checksum expected.
- When undefined: the GET_SUM state and its logic are absent, and frames are exactly as listed above.

Test Plan:
- Write path: tx_ready_i=1; send 'W',0x12,0xA5 → reg_write_o one pulse 1 cycle after the 0xA5 strobe, with addr=0x12 and wdata=0xA5; then tx_write_o one pulse with tx_data_o=0x4B.
- Read path: send 'R',0x34 with the model returning 0x5C → reg_read_o one pulse with addr=0x34; then tx_data_o=0x5C written once.
- Backpressure and overrun: 'P' with tx_ready_i=0 for 50 cycles, plus an extra byte 0x57 sent meanwhile → error_o one pulse, no write before tx_ready_i rises; exactly one tx_write_o with 0x50, then IDLE with no frame started.
- Timeout: TIMEOUT_CYCLES=100; send 'W',0x01, then silence for 100 cycles → error_o one pulse, busy_o falls, no reg_write_o, no tx_write_o; a following 'P' responds 0x50.
- Bad opcode plus reset: send 0x41 → '?' response and error_o. Then assert reset_n low mid-frame after 'W' → all outputs 0 immediately (asynchronous) and no response after release.
- With UART_CMD_CHECKSUM_EN: send 'W',0x12,0xA5,0xE0 → write occurs and 'K' is returned; send 'W',0x12,0xA5,0x00 → no write, '!' returned, error_o pulses.
